regfile_read_stage: RTL and testbench

- Consumer end of the write-back path: holds the 8-entry 16-bit architectural register file and accepts the write-back stage's register write (data, destination, write enable).
- On the read side, serves two source operands to the execute stage through a registered ID/EX boundary.
- Tracks in-flight destination writes with per-register pending counters and raises a stall to decode on read-after-write or counter-saturation hazards.
- Forwards a same-cycle write-back value straight into the operand read.

---
 rtl/regfile_read_stage.sv | 110 +++++++++++
 tb/tb_regfile_read_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_stage.sv
// Register file with write-back port, pending-write scoreboard,
// same-cycle bypass and a registered ID/EX operand boundary.
module regfile_read_stage #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int PEND_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_writes_rd,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_writes_rd
);

    localparam int NREG = 1 << ADDR_W;
    localparam int CW   = $clog2(PEND_MAX + 1);

    logic [DATA_W-1:0] regs    [NREG];
    logic [CW-1:0]     cnt     [NREG];
    logic [CW-1:0]     cnt_nxt [NREG];

    logic              hit1, hit2;
    logic              haz1, haz2, sat;
    logic              issue;
    logic [DATA_W-1:0] op1, op2;

    always_comb begin
        hit1 = wb_regwrite && (wb_addr == id_rs1);
        hit2 = wb_regwrite && (wb_addr == id_rs2);

        op1 = regs[id_rs1];
        if (id_rs1 == '0)
            op1 = '0;
        else if (hit1)
            op1 = wb_data;

        op2 = regs[id_rs2];
        if (id_rs2 == '0)
            op2 = '0;
        else if (hit2)
            op2 = wb_data;

        // a retiring last-pending write is picked up by the bypass
        haz1 = (id_rs1 != '0) && (cnt[id_rs1] != '0)
            && !(hit1 && (cnt[id_rs1] == CW'(1)));
        haz2 = (id_rs2 != '0) && (cnt[id_rs2] != '0)
            && !(hit2 && (cnt[id_rs2] == CW'(1)));
        sat  = id_writes_rd && (id_rd != '0)
            && (cnt[id_rd] == CW'(PEND_MAX));

        stall = id_valid && ((id_uses_rs1 && haz1)
            || (id_uses_rs2 && haz2) || sat);
        issue = id_valid && !stall;
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            logic inc, dec;
            inc = issue && id_writes_rd && (id_rd == ADDR_W'(i));
            dec = wb_regwrite && (wb_addr == ADDR_W'(i));
            cnt_nxt[i] = cnt[i];
            if (i == 0)
                cnt_nxt[i] = '0;
            else if (inc && !dec)
                cnt_nxt[i] = cnt[i] + CW'(1);
            else if (dec && !inc && (cnt[i] != '0))
                cnt_nxt[i] = cnt[i] - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            ex_valid     <= 1'b0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rd        <= '0;
            ex_writes_rd <= 1'b0;
        end else begin
            if (wb_regwrite && (wb_addr != '0))
                regs[wb_addr] <= wb_data;
            for (int i = 0; i < NREG; i++)
                cnt[i] <= cnt_nxt[i];
            ex_valid     <= issue;
            ex_writes_rd <= issue && id_writes_rd;
            if (issue) begin
                ex_rs1_data <= op1;
                ex_rs2_data <= op2;
                ex_rd       <= id_rd;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed bench for regfile_read_stage: bypass, RAW stall,
// counter saturation, r0 rules and async reset.
module tb_regfile_read_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_regwrite;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        id_valid;
    logic [2:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2, id_writes_rd;
    logic        stall, ex_valid, ex_writes_rd;
    logic [15:0] ex_rs1_data, ex_rs2_data;
    logic [2:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    regfile_read_stage dut (
        .clk          (clk),
        .reset        (reset),
        .wb_regwrite  (wb_regwrite),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_writes_rd (id_writes_rd),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_rd        (ex_rd),
        .ex_writes_rd (ex_writes_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wb_regwrite  = 0; wb_addr = 0; wb_data = 0;
        id_valid     = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_uses_rs1  = 0; id_uses_rs2 = 0; id_writes_rd = 0;
    endtask

    task automatic ne();
        @(negedge clk);
        clr();
    endtask

    task automatic pe();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_op(input logic [2:0] r1, input logic [2:0] r2);
        id_valid = 1; id_rs1 = r1; id_rs2 = r2;
        id_uses_rs1 = 1; id_uses_rs2 = 1;
    endtask

    task automatic wr_op(input logic [2:0] rd);
        id_valid = 1; id_rd = rd; id_writes_rd = 1;
    endtask

    task automatic wb(input logic [2:0] a, input logic [15:0] d);
        wb_regwrite = 1; wb_addr = a; wb_data = d;
    endtask

    initial begin
        clr();
        reset = 0;
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_ex_rs1", 32'(ex_rs1_data), 0);
        chk("rst_ex_wr", 32'(ex_writes_rd), 0);
        pe(); pe();
        @(negedge clk);
        reset = 1;

        ne(); rd_op(3, 5); #1;
        chk("s1_stall", 32'(stall), 0);
        pe();
        chk("s1_valid", 32'(ex_valid), 1);
        chk("s1_rs1", 32'(ex_rs1_data), 0);
        chk("s1_rs2", 32'(ex_rs2_data), 0);

        ne(); wb(2, 16'hBEEF); rd_op(2, 0); #1;
        chk("byp_stall", 32'(stall), 0);
        pe();
        chk("byp_rs1", 32'(ex_rs1_data), 16'hBEEF);
        chk("byp_rs2", 32'(ex_rs2_data), 0);

        ne(); rd_op(2, 2);
        pe();
        chk("arr_rs1", 32'(ex_rs1_data), 16'hBEEF);
        chk("arr_rs2", 32'(ex_rs2_data), 16'hBEEF);

        ne(); wr_op(4); #1;
        chk("w4_stall", 32'(stall), 0);
        pe();
        chk("w4_rd", 32'(ex_rd), 4);
        chk("w4_wr", 32'(ex_writes_rd), 1);

        ne(); rd_op(4, 0); #1;
        chk("raw_stall0", 32'(stall), 1);
        pe();
        chk("raw_bub_v", 32'(ex_valid), 0);
        chk("raw_bub_wr", 32'(ex_writes_rd), 0);
        chk("raw_hold_rd", 32'(ex_rd), 4);
        chk("raw_hold_rs1", 32'(ex_rs1_data), 0);

        ne(); rd_op(4, 0); #1;
        chk("raw_stall1", 32'(stall), 1);
        pe();

        ne(); rd_op(4, 0); wb(4, 16'h1234); #1;
        chk("raw_release", 32'(stall), 0);
        pe();
        chk("raw_valid", 32'(ex_valid), 1);
        chk("raw_rs1", 32'(ex_rs1_data), 16'h1234);

        ne(); rd_op(4, 0); #1;
        chk("r4_free", 32'(stall), 0);
        pe();
        chk("r4_data", 32'(ex_rs1_data), 16'h1234);

        for (int k = 0; k < 3; k++) begin
            ne(); wr_op(6); #1;
            chk("w6_nostall", 32'(stall), 0);
            pe();
        end
        ne(); wr_op(6); #1;
        chk("w6_sat", 32'(stall), 1);
        pe();
        chk("w6_sat_bub", 32'(ex_valid), 0);
        ne(); wr_op(6); wb(6, 16'h0666); #1;
        chk("w6_sat_wb", 32'(stall), 1);
        pe();
        ne(); wr_op(6); #1;
        chk("w6_issue", 32'(stall), 0);
        pe();
        chk("w6_issue_v", 32'(ex_valid), 1);
        ne(); wr_op(6); #1;
        chk("w6_resat", 32'(stall), 1);
        pe();

        ne(); wb(0, 16'hFFFF); rd_op(0, 0); #1;
        chk("r0_stall", 32'(stall), 0);
        pe();
        chk("r0_byp", 32'(ex_rs1_data), 0);
        ne(); rd_op(0, 0);
        pe();
        chk("r0_arr", 32'(ex_rs1_data), 0);
        for (int k = 0; k < 4; k++) begin
            ne(); wr_op(0); #1;
            chk("r0_wr_stall", 32'(stall), 0);
            pe();
        end
        ne(); rd_op(0, 0); #1;
        chk("r0_not_pend", 32'(stall), 0);
        pe();

        ne(); wr_op(1);
        id_rs1 = 1; id_uses_rs1 = 1; #1;
        chk("self_src", 32'(stall), 0);
        pe();
        ne(); wr_op(1); #1;
        chk("w1_b", 32'(stall), 0);
        pe();
        chk("w1_valid", 32'(ex_valid), 1);
        ne(); rd_op(1, 0); #1;
        chk("c1_2_stall", 32'(stall), 1);
        reset = 0; #1;
        chk("arst_valid", 32'(ex_valid), 0);
        chk("arst_wr", 32'(ex_writes_rd), 0);
        chk("arst_rd", 32'(ex_rd), 0);
        chk("arst_rs1", 32'(ex_rs2_data) | 32'(ex_rs1_data), 0);
        chk("arst_cnt", 32'(stall), 0);
        pe();
        @(negedge clk);
        reset = 1;

        ne(); rd_op(1, 2); #1;
        chk("post_r1", 32'(stall), 0);
        pe();
        chk("post_r2_clr", 32'(ex_rs2_data), 0);
        ne(); wr_op(6); #1;
        chk("post_r6", 32'(stall), 0);
        pe();
        ne(); wb(1, 16'h0055);
        pe();
        ne(); rd_op(1, 0); #1;
        chk("late_wb_st", 32'(stall), 0);
        pe();
        chk("late_wb_d", 32'(ex_rs1_data), 16'h0055);

        ne();
        pe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
